udp_tx_sched: RTL
=================

# udp_tx_sched

Round-robin scheduler that shares one `udp_send` + `rmii_send_byte` transmit path between up to NREQ measurement sources (jitter loggers, counters, status). Each source raises a one-cycle request with a data snapshot. The block holds one pending snapshot per source and counts overwritten snapshots as drops. It serialises frames into the UDP core, builds the payload header (source id, sequence, drops) and enforces a minimum inter-frame gap. It sits between the `ws_log_max` instances and `udp_send` in the logger top level.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- DB, 12, data bytes per requester snapshot
- P_SZ, 18, payload size in bytes given to `udp_send`; must be ≥ DB+4
- GAP, 200, minimum idle clk cycles between end of one frame and next start
- TMO, 15, cycles to wait for `udp_send` to go busy after start

Ports:
- clk  in  1  system clock (100 MHz)
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NREQ  per-source request pulse, one cycle
- req_data  in  NREQ*DB*8  per-source snapshot, source i at bits [i*DB*8 +: DB*8], byte 0 in the LSBs
- start  out  1  one-cycle start pulse to `udp_send`
- addr  in  7  payload byte address from `udp_send`
- payload  out  8  payload byte for `addr`, combinational
- udp_rdy  in  1  `udp_send` idle flag (high = idle)
- sent  out  1  one-cycle pulse when a frame completes
- busy  out  1  high whenever the FSM is not in IDLE
- tmo_err  out  1  sticky flag: `udp_send` failed to go busy; cleared only by reset

## Operation
- Per source i: `hold[i]` (DB bytes), `pend[i]`, `drop[i]` (8-bit, saturating at 255).
- Request capture: when `req[i]` is high, `hold[i]` takes the value of `req_data` slice i and `pend[i]` is set to 1.
  - If `pend[i]` was already 1 and source i is not being loaded in this cycle, `drop[i]` increments.
- Frame payload layout: byte0 = source id, byte1/2 = seq[7:0]/seq[15:8], byte3 = drop count, bytes 4..DB+3 = snapshot, remaining bytes up to P_SZ-1 = 0.
- `payload` = frame[addr] when addr < P_SZ, otherwise 0.
- seq is a 16-bit global counter. It increments at every LOAD and wraps from 0xFFFF to 0x0000.
- FSM states:
  - IDLE: if any `pend` bit is set, go to LOAD.
  - LOAD: the winner w is the first pending source scanning upward from last+1 (mod NREQ).
    - Copy `hold[w]`, w, seq and `drop[w]` into the frame buffer.
    - Clear `pend[w]`, set `drop[w]` to 0, set last = w, increment seq.
    - Go to START.
  - START: assert `start`; go to WAIT_BUSY.
  - WAIT_BUSY: when `udp_rdy` is 0, go to WAIT_DONE. After TMO cycles without it, set `tmo_err` and go to GAP.
  - WAIT_DONE: when `udp_rdy` is 1, pulse `sent` and go to GAP.
  - GAP: count GAP cycles, then go to IDLE.
- Request on the winner during LOAD: the frame takes the old `hold[w]`. `hold[w]` takes the new data, `pend[w]` stays 1, and no drop is counted.
- The frame buffer is held stable from LOAD until the FSM exits WAIT_DONE. Requests during a frame update only `hold`/`pend`.

## Timing
- Reset values: start=0, sent=0, busy=0, tmo_err=0, payload reflects a frame buffer of 0, pend=0, drop=0, seq=0, last=NREQ-1 (so source 0 wins first), state IDLE.
- Latency from idle: `req` at cycle t, LOAD at t+1, `start` high at t+2.
- `pend` is visible the cycle after `req`.
- Minimum spacing between consecutive `start` pulses = frame duration + GAP + 3 cycles.
- Reset mid-frame: all state clears immediately. `start` drops asynchronously, and any frame in flight in `udp_send` is not tracked.
- Simultaneous requests from all sources: they are served in round-robin order with no loss, provided no source repeats before it is served.

## Structure
- Shared package `udp_sched_pkg`:
  - FSM state enum.
  - Header byte offsets: OFS_ID=0, OFS_SEQ=1, OFS_DROP=3, OFS_DATA=4.
  - Drop saturation constant 8'hFF.
- Sub-module `rr_arbiter`: input NREQ pending vector and last pointer; output one-hot grant and encoded winner; combinational.

## Test plan
- Single request, source 2, data 0x0B..0x00: `start` at t+2. Payload bytes 0..3 = 02,00,00,00; bytes 4..15 = 00..0B; bytes 16,17 = 00. `sent` after `udp_rdy` returns high.
- All four sources request in the same cycle: frames go out in order 0,1,2,3 with seq 0..3, each spaced by ≥ GAP idle cycles.
- Source 1 requests 3 times while a frame is in flight: the next source-1 frame carries the latest data with drop=2; the following frame carries drop=0.
- Source 0 requests 300 times without being served (`udp_rdy` held low): the drop count saturates and the frame byte3 = 0xFF.
- `udp_rdy` stuck high after start: `tmo_err` is set TMO cycles later, the FSM passes through GAP and returns to IDLE, and the next request is served.
- Preload seq = 0xFFFF via 65535 frames (or force): the next frames show seq 0xFFFF then 0x0000. Asserting `rst_n` low mid-WAIT_DONE clears busy, pend and seq in the same cycle.

Source files
------------

// File: rtl/udp_sched_pkg.sv
// Shared definitions for the UDP transmit scheduler.
// - state_e       : scheduler FSM states
// - OFS_*         : byte offsets of the payload header fields
// - DROP_SAT      : saturation value of the per-source drop counters
// - drop_inc()    : saturating increment of a drop counter
package udp_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_e;

  localparam int unsigned OFS_ID   = 0;
  localparam int unsigned OFS_SEQ  = 1;
  localparam int unsigned OFS_DROP = 3;
  localparam int unsigned OFS_DATA = 4;

  localparam logic [7:0] DROP_SAT = 8'hFF;

  function automatic logic [7:0] drop_inc(input logic [7:0] d);
    return (d == DROP_SAT) ? d : d + 8'd1;
  endfunction

endpackage

// File: rtl/udp_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   pend   in  NREQ  pending request vector
//   last   in  LW    index of the previously served source
//   grant  out NREQ  one-hot grant (all zero when nothing is pending)
//   winner out LW    encoded grant index (equals last when nothing is pending)
// The search starts at last+1 and wraps modulo NREQ, so last itself is
// considered only after every other source.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] pend,
  input  logic [LW-1:0]   last,
  output logic [NREQ-1:0] grant,
  output logic [LW-1:0]   winner
);

  logic [LW-1:0] idx;
  logic          found;

  always_comb begin
    grant  = '0;
    winner = last;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = LW'((32'(last) + k) % NREQ);
      if (!found && pend[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = idx;
      end
    end
  end

endmodule

// File: rtl/udp_tx_sched.sv
// Round-robin scheduler sharing one udp_send transmit path between NREQ
// measurement sources. Each source posts a one-cycle request with a data
// snapshot; one snapshot per source is held, overwritten snapshots are
// counted as drops, and frames are built with a header (id, seq, drops).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   req         per-source one-cycle request
//   req_data    per-source snapshot, source i at [i*DB*8 +: DB*8], byte 0 in LSBs
//   start       one-cycle start pulse to udp_send
//   addr        payload byte address from udp_send
//   payload     frame byte at addr (0 beyond P_SZ), combinational
//   udp_rdy     udp_send idle flag
//   sent        one-cycle pulse when a frame completes
//   busy        FSM not idle
//   tmo_err     sticky: udp_send never went busy after start
module udp_tx_sched
  import udp_sched_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DB   = 12,
  parameter int unsigned P_SZ = 18,
  parameter int unsigned GAP  = 200,
  parameter int unsigned TMO  = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DB*8-1:0] req_data,
  output logic                 start,
  input  logic [6:0]           addr,
  output logic [7:0]           payload,
  input  logic                 udp_rdy,
  output logic                 sent,
  output logic                 busy,
  output logic                 tmo_err
);

  localparam int unsigned LW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CMAX = (GAP > TMO) ? GAP : TMO;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  state_e                   state_q, state_d;
  logic [NREQ-1:0][DB*8-1:0] hold_q, hold_d;
  logic [NREQ-1:0]          pend_q, pend_d;
  logic [NREQ-1:0][7:0]     drop_q, drop_d;
  logic [15:0]              seq_q, seq_d;
  logic [LW-1:0]            last_q, last_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     tmo_err_q, tmo_err_d;

  logic [LW-1:0]            fr_id_q, fr_id_d;
  logic [15:0]              fr_seq_q, fr_seq_d;
  logic [7:0]               fr_drop_q, fr_drop_d;
  logic [DB*8-1:0]          fr_data_q, fr_data_d;

  logic [NREQ-1:0]          grant;
  logic [LW-1:0]            winner;
  logic                     load;

  rr_arbiter #(
    .NREQ (NREQ),
    .LW   (LW)
  ) u_arb (
    .pend   (pend_q),
    .last   (last_q),
    .grant  (grant),
    .winner (winner)
  );

  // FSM. IDLE also reacts to a request arriving in the same cycle so that
  // LOAD follows the request cycle directly; pend is set on that same edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_err_d = tmo_err_q;
    start     = 1'b0;
    sent      = 1'b0;
    load      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((|pend_q) || (|req)) state_d = S_LOAD;
      end
      S_LOAD: begin
        load    = 1'b1;
        state_d = S_START;
      end
      S_START: begin
        start   = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!udp_rdy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CW'(TMO - 1)) begin
          tmo_err_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (udp_rdy) begin
          sent    = 1'b1;
          cnt_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == CW'(GAP - 1)) state_d = S_IDLE;
        else                       cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Per-source capture and frame load. The LOAD clear is applied first so a
  // request on the winner in the same cycle re-arms pend without a drop,
  // while the frame still takes the old hold contents.
  always_comb begin
    hold_d    = hold_q;
    pend_d    = pend_q;
    drop_d    = drop_q;
    seq_d     = seq_q;
    last_d    = last_q;
    fr_id_d   = fr_id_q;
    fr_seq_d  = fr_seq_q;
    fr_drop_d = fr_drop_q;
    fr_data_d = fr_data_q;

    if (load) begin
      fr_id_d        = winner;
      fr_seq_d       = seq_q;
      fr_drop_d      = drop_q[winner];
      fr_data_d      = hold_q[winner];
      pend_d         = pend_q & ~grant;
      drop_d[winner] = '0;
      last_d         = winner;
      seq_d          = seq_q + 16'd1;
    end

    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req[i]) begin
        hold_d[i] = req_data[i*DB*8 +: DB*8];
        if (pend_q[i] && !(load && grant[i])) drop_d[i] = drop_inc(drop_q[i]);
        pend_d[i] = 1'b1;
      end
    end
  end

  int unsigned     pa;
  logic [DB*8-1:0] pdat;

  always_comb begin
    pa      = 32'(addr);
    pdat    = '0;
    payload = '0;
    if (pa < P_SZ) begin
      if (pa == OFS_ID) begin
        payload = 8'(fr_id_q);
      end else if (pa == OFS_SEQ) begin
        payload = fr_seq_q[7:0];
      end else if (pa == OFS_SEQ + 1) begin
        payload = fr_seq_q[15:8];
      end else if (pa == OFS_DROP) begin
        payload = fr_drop_q;
      end else if (pa >= OFS_DATA && pa < OFS_DATA + DB) begin
        pdat    = fr_data_q >> (8 * (pa - OFS_DATA));
        payload = pdat[7:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      hold_q    <= '0;
      pend_q    <= '0;
      drop_q    <= '0;
      seq_q     <= '0;
      last_q    <= LW'(NREQ - 1);
      cnt_q     <= '0;
      tmo_err_q <= 1'b0;
      fr_id_q   <= '0;
      fr_seq_q  <= '0;
      fr_drop_q <= '0;
      fr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      pend_q    <= pend_d;
      drop_q    <= drop_d;
      seq_q     <= seq_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      tmo_err_q <= tmo_err_d;
      fr_id_q   <= fr_id_d;
      fr_seq_q  <= fr_seq_d;
      fr_drop_q <= fr_drop_d;
      fr_data_q <= fr_data_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign tmo_err = tmo_err_q;

endmodule
